// File: rtl/set_assoc_cache_ctrl.sv
// 4-way set-associative, one-word-per-line cache controller with write-through,
// read allocation, tree pseudo-LRU replacement and saturating hit/miss statistics.
module set_assoc_cache_ctrl #(
  parameter int TAG_W   = 22,
  parameter int INDEX_W = 8,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  stat_hits,
  output logic [CNT_W-1:0]  stat_misses
);

  localparam int WAYS   = 4;
  localparam int SETS   = 1 << INDEX_W;
  localparam int LINE_W = TAG_W + INDEX_W;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_MEM_RD = 3'd2;
  localparam logic [2:0] ST_MEM_WR = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [DATA_W-1:0] data_mem [WAYS][SETS];
  logic [WAYS-1:0]   valid_r  [SETS];
  // plru_r[s] = {b2, b1, b0}
  logic [2:0]        plru_r   [SETS];

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic              we_r;
  logic [LINE_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;

  logic [INDEX_W-1:0] set_idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic [WAYS-1:0]    match_s;
  logic               hit_s;
  logic [1:0]         hit_way_s;
  logic [1:0]         victim_s;
  logic [1:0]         way_sel_s;
  logic [DATA_W-1:0]  data_in_s;
  logic               data_we_s;
  logic               tag_we_s;
  logic               plru_we_s;
  logic               data_wr_s;
  logic               tag_wr_s;
  logic               plru_wr_s;
  logic               addr_lsb_unused_s;

  function automatic logic [1:0] first_way(input logic [WAYS-1:0] m);
    if (m[0]) begin
      first_way = 2'd0;
    end else if (m[1]) begin
      first_way = 2'd1;
    end else if (m[2]) begin
      first_way = 2'd2;
    end else begin
      first_way = 2'd3;
    end
  endfunction

  // Invalid ways are always preferred over evicting a live line.
  function automatic logic [1:0] pick_victim(input logic [WAYS-1:0] v, input logic [2:0] p);
    if (!v[0]) begin
      pick_victim = 2'd0;
    end else if (!v[1]) begin
      pick_victim = 2'd1;
    end else if (!v[2]) begin
      pick_victim = 2'd2;
    end else if (!v[3]) begin
      pick_victim = 2'd3;
    end else if (!p[0]) begin
      pick_victim = p[1] ? 2'd1 : 2'd0;
    end else begin
      pick_victim = p[2] ? 2'd3 : 2'd2;
    end
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
    case (w)
      2'd0:    plru_touch = {p[2], 1'b1, 1'b1};
      2'd1:    plru_touch = {p[2], 1'b0, 1'b1};
      2'd2:    plru_touch = {1'b1, p[1], 1'b0};
      2'd3:    plru_touch = {1'b0, p[1], 1'b0};
      default: plru_touch = p;
    endcase
  endfunction

  assign addr_lsb_unused_s = ^cpu_addr[1:0];
  assign set_idx_s = addr_r[INDEX_W-1:0];
  assign tag_s     = addr_r[LINE_W-1:INDEX_W];
  assign hit_s     = |match_s;
  assign hit_way_s = first_way(match_s);
  assign victim_s  = pick_victim(valid_r[set_idx_s], plru_r[set_idx_s]);
  assign data_wr_s = data_we_s & ~rst;
  assign tag_wr_s  = tag_we_s & ~rst;
  assign plru_wr_s = plru_we_s & ~rst;

  // Tag compare across the four ways of the addressed set
  always_comb begin
    match_s = {WAYS{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      match_s[w] = valid_r[set_idx_s][w] && (tag_mem[w][set_idx_s] == tag_s);
    end
  end

  // Next state and array write enables
  always_comb begin
    state_nxt_s = state_r;
    data_we_s   = 1'b0;
    tag_we_s    = 1'b0;
    plru_we_s   = 1'b0;
    way_sel_s   = hit_way_s;
    data_in_s   = wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req) begin
          state_nxt_s = ST_LOOKUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (hit_s) begin
          plru_we_s = 1'b1;
          if (we_r) begin
            data_we_s   = 1'b1;
            state_nxt_s = ST_MEM_WR;
          end else begin
            state_nxt_s = ST_RESP;
          end
        end else begin
          state_nxt_s = we_r ? ST_MEM_WR : ST_MEM_RD;
        end
      end
      ST_MEM_RD: begin
        if (mem_ack) begin
          way_sel_s   = victim_s;
          data_in_s   = mem_rdata;
          data_we_s   = 1'b1;
          tag_we_s    = 1'b1;
          plru_we_s   = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_MEM_RD;
        end
      end
      ST_MEM_WR: begin
        if (mem_ack) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_MEM_WR;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Control registers, registered CPU/memory outputs and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      we_r        <= 1'b0;
      addr_r      <= {LINE_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      cpu_ready   <= 1'b0;
      cpu_rdata   <= {DATA_W{1'b0}};
      cpu_hit     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0000_0000;
      mem_wdata   <= {DATA_W{1'b0}};
      stat_hits   <= {CNT_W{1'b0}};
      stat_misses <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      cpu_ready <= (state_nxt_s == ST_RESP);
      case (state_r)
        ST_IDLE: begin
          if (cpu_req) begin
            we_r    <= cpu_we;
            addr_r  <= cpu_addr[LINE_W+1:2];
            wdata_r <= cpu_wdata;
          end
        end
        ST_LOOKUP: begin
          cpu_hit <= hit_s;
          if (hit_s) begin
            if (stat_hits != CNT_MAX) stat_hits <= stat_hits + CNT_ONE;
            if (!we_r) cpu_rdata <= data_mem[hit_way_s][set_idx_s];
          end else begin
            if (stat_misses != CNT_MAX) stat_misses <= stat_misses + CNT_ONE;
          end
          if (state_nxt_s == ST_MEM_RD || state_nxt_s == ST_MEM_WR) begin
            mem_req  <= 1'b1;
            mem_we   <= we_r;
            mem_addr <= {addr_r, 2'b00};
            if (we_r) mem_wdata <= wdata_r;
          end
        end
        ST_MEM_RD: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            cpu_rdata <= mem_rdata;
          end
        end
        ST_MEM_WR: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        ST_RESP: begin
        end
        default: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

  // Valid and PLRU state, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= {WAYS{1'b0}};
        plru_r[s]  <= 3'b000;
      end
    end else begin
      if (tag_wr_s) valid_r[set_idx_s][way_sel_s] <= 1'b1;
      if (plru_wr_s) plru_r[set_idx_s] <= plru_touch(plru_r[set_idx_s], way_sel_s);
    end
  end

  // Tag and data storage; contents survive reset
  always_ff @(posedge clk) begin
    if (tag_wr_s) tag_mem[way_sel_s][set_idx_s] <= tag_s;
    if (data_wr_s) data_mem[way_sel_s][set_idx_s] <= data_in_s;
  end

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Scoreboard bench for set_assoc_cache_ctrl: a reference cache model predicts each
// response when a request is driven; responses are popped and compared on cpu_ready.
module tb_set_assoc_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_hit;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [15:0] stat_hits;
  logic [15:0] stat_misses;

  set_assoc_cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic        hit;
    logic        mem;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb_q[$];
  int n_vectors = 0;
  int n_miscompares = 0;

  logic        m_valid [256][4];
  logic [21:0] m_tag   [256][4];
  logic [31:0] m_data  [256][4];
  logic        m_b0 [256];
  logic        m_b1 [256];
  logic        m_b2 [256];
  int          m_hits;
  int          m_misses;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 256; s++) begin
      for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
      m_b0[s] = 1'b0; m_b1[s] = 1'b0; m_b2[s] = 1'b0;
    end
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic model_touch(input int s, input int w);
    if (w == 0) begin m_b0[s] = 1'b1; m_b1[s] = 1'b1; end
    else if (w == 1) begin m_b0[s] = 1'b1; m_b1[s] = 1'b0; end
    else if (w == 2) begin m_b0[s] = 1'b0; m_b2[s] = 1'b1; end
    else begin m_b0[s] = 1'b0; m_b2[s] = 1'b0; end
  endtask

  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] md, input int wait_cyc, output exp_t e);
    int s, hw, v;
    logic [21:0] t;
    s = int'(addr[9:2]);
    t = addr[31:10];
    hw = -1;
    for (int w = 3; w >= 0; w--) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    e.we = we;
    e.hit = (hw >= 0);
    e.mem = we || (hw < 0);
    e.addr = {addr[31:2], 2'b00};
    e.wdata = wd;
    e.rdata = 32'h0;
    e.lat = (hw >= 0 && !we) ? 8'd2 : 8'(3 + wait_cyc);
    if (hw >= 0) begin
      if (m_hits < 65535) m_hits++;
      model_touch(s, hw);
      if (we) m_data[s][hw] = wd;
      e.rdata = m_data[s][hw];
    end else begin
      if (m_misses < 65535) m_misses++;
      if (!we) begin
        v = -1;
        for (int w = 3; w >= 0; w--) if (!m_valid[s][w]) v = w;
        if (v < 0) v = m_b0[s] ? (m_b2[s] ? 3 : 2) : (m_b1[s] ? 1 : 0);
        m_valid[s][v] = 1'b1;
        m_tag[s][v] = t;
        m_data[s][v] = md;
        model_touch(s, v);
        e.rdata = md;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    sb_q.delete();
    check_value("rst_ready", cpu_ready, 1'b0);
    check_value("rst_memreq", mem_req, 1'b0);
    check_value("rst_memwe", mem_we, 1'b0);
    check_value("rst_hit", cpu_hit, 1'b0);
    check_value("rst_rdata", cpu_rdata, 32'h0);
    check_value("rst_stats", {stat_hits, stat_misses}, 32'h0);
  endtask

  // One CPU request; memory answers after wait_cyc cycles; poke keeps cpu_req high meanwhile.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] md, input int wait_cyc, input logic poke);
    exp_t e, got;
    int n, waited;
    logic seen_mem, done;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    model_access(we, addr, wd, md, wait_cyc, e);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cpu_req = poke; cpu_we = 1'b0; cpu_addr = 32'hFFFF_FFFC; cpu_wdata = 32'h0;
    n = 1; waited = 0; seen_mem = 1'b0; done = 1'b0;
    while (!done && n < 60) begin
      if (cpu_ready) begin
        got = sb_q.pop_front();
        check_value("ready_latency", n, got.lat);
        check_value("cpu_hit", cpu_hit, got.hit);
        if (!got.we) check_value("cpu_rdata", cpu_rdata, got.rdata);
        check_value("mem_used", seen_mem, got.mem);
        done = 1'b1;
      end else if (mem_req) begin
        if (!seen_mem || waited == wait_cyc) begin
          check_value("mem_we", mem_we, e.we);
          check_value("mem_addr", mem_addr, e.addr);
          if (e.we) check_value("mem_wdata", mem_wdata, e.wdata);
        end
        seen_mem = 1'b1;
        if (waited == wait_cyc) begin
          mem_ack = 1'b1; mem_rdata = md; cpu_req = 1'b0;
        end else begin
          waited++;
          mem_rdata = 32'hBAD0_0000 | 32'(waited);
        end
      end
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'h0;
      n++;
    end
    cpu_req = 1'b0;
    check_value("ready_timeout", done, 1'b1);
    if (!done && sb_q.size() > 0) got = sb_q.pop_front();
    check_value("stat_hits", stat_hits, 16'(m_hits));
    check_value("stat_misses", stat_misses, 16'(m_misses));
    @(negedge clk);
    check_value("ready_pulse", cpu_ready, 1'b0);
  endtask

  function automatic logic [31:0] sa(input int tag, input int idx);
    sa = {tag[21:0], idx[7:0], 2'b00};
  endfunction

  initial begin
    model_reset();
    apply_reset();

    // Cold miss with two wait cycles, then a hit on the same word
    do_req(1'b0, 32'h0000_0404, 32'h0, 32'hDEAD_BEEF, 2, 1'b0);
    do_req(1'b0, 32'h0000_0404, 32'h0, 32'h0, 0, 1'b0);

    // Five misses into set 1; fifth evicts way0
    apply_reset();
    for (int t = 1; t <= 5; t++) do_req(1'b0, sa(t, 1), 32'h0, 32'h1000_0000 + 32'(t), t % 3, 1'b0);
    do_req(1'b0, sa(1, 1), 32'h0, 32'h2000_0001, 0, 1'b0);
    do_req(1'b0, sa(2, 1), 32'h0, 32'h0, 0, 1'b0);

    // PLRU: touching tag1 steers the next victim to way2
    apply_reset();
    for (int t = 1; t <= 4; t++) do_req(1'b0, sa(t, 1), 32'h0, 32'h3000_0000 + 32'(t), 0, 1'b0);
    do_req(1'b0, sa(1, 1), 32'h0, 32'h0, 0, 1'b0);
    do_req(1'b0, sa(5, 1), 32'h0, 32'h3000_0005, 1, 1'b0);
    do_req(1'b0, sa(1, 1), 32'h0, 32'h0, 0, 1'b0);
    do_req(1'b0, sa(4, 1), 32'h0, 32'h0, 0, 1'b0);
    do_req(1'b0, sa(3, 1), 32'h0, 32'h3000_0033, 0, 1'b0);

    // Write hit updates the line; write miss is write-through only
    do_req(1'b1, sa(4, 1), 32'h1234_5678, 32'h0, 1, 1'b0);
    do_req(1'b0, sa(4, 1), 32'h0, 32'h0, 0, 1'b0);
    do_req(1'b1, 32'h0000_8808, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
    do_req(1'b0, 32'h0000_8808, 32'h0, 32'h4444_0000, 0, 1'b0);

    // Reset while waiting in MEM_RD aborts the fill
    apply_reset();
    do_req(1'b0, 32'h0000_0C0C, 32'h0, 32'h5555_AAAA, 0, 1'b0);
    do_req(1'b0, 32'h0000_0C0C, 32'h0, 32'h0, 0, 1'b0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_2010;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
    check_value("abort_memreq_up", mem_req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_value("abort_memreq", mem_req, 1'b0);
    check_value("abort_stats", {stat_hits, stat_misses}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check_value("abort_no_ready", cpu_ready, 1'b0);
      mem_ack = (i == 1);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    do_req(1'b0, 32'h0000_0C0C, 32'h0, 32'h6666_0000, 0, 1'b0);

    // Stray mem_ack in IDLE, cpu_req held during MEM_RD
    @(negedge clk);
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_value("idle_ack_memreq", mem_req, 1'b0);
      check_value("idle_ack_ready", cpu_ready, 1'b0);
    end
    mem_ack = 1'b0;
    do_req(1'b0, 32'h0001_2344, 32'h0, 32'h7777_1234, 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_value("poke_single_ready", cpu_ready, 1'b0);
      check_value("poke_no_memreq", mem_req, 1'b0);
    end

    // Mixed random traffic over two sets
    for (int i = 0; i < 40; i++) begin
      do_req(($urandom_range(0, 3) == 0), sa($urandom_range(1, 6), 3 + (i % 2)),
             $urandom, $urandom, $urandom_range(0, 2), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
